cic_comb_decim: RTL

CIC_COMB_DECIM -- requirements
Module: cic_comb_decim

---
 rtl/cic_pkg.sv | 14 +
 rtl/cic_comb_decim.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cic_pkg.sv
// Shared CIC constants and types, used by the integrator and comb/decimator stages.
package cic_pkg;

    // Number of independent channels carried through the CIC chain.
    localparam int CIC_N_CH = 4;

    // Default sample width and decimation-field width.
    localparam int CIC_WIDTH_DEF   = 64;
    localparam int CIC_DECIM_W_DEF = 10;

    // Channel index; two bits covers channels 0..3.
    typedef logic [1:0] cic_ch_t;

endpackage : cic_pkg

// File: rtl/cic_comb_decim.sv
// CIC comb + decimator stage for four interleaved channels.
// Each channel has its own decimation counter, delay register and primed flag.
// On a decimation event, a primed channel produces x[n] - x[n-1]. An unprimed
// channel only loads its delay register, which suppresses the startup transient.
// The output register follows a valid/ready handshake.
// Handshake: a result transfers when valid_o and ready_i are both high on a
// rising edge. data_o and ch_o stay stable while valid_o=1 and ready_i=0.
// A result that arrives while the output is stalled is dropped, and the sticky
// ovf_o flag records the drop.
module cic_comb_decim
    import cic_pkg::*;
#(
    parameter int WIDTH   = CIC_WIDTH_DEF,
    parameter int DECIM_W = CIC_DECIM_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic [DECIM_W-1:0] decim_i,
    input  logic               valid_i,
    input  cic_ch_t            ch_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output cic_ch_t            ch_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               ovf_o
);

    localparam logic [DECIM_W-1:0] CNT_ONE = {{(DECIM_W-1){1'b0}}, 1'b1};

    // Per-channel state
    logic [DECIM_W-1:0] cnt_q [CIC_N_CH];
    logic [DECIM_W-1:0] cnt_d [CIC_N_CH];
    logic [WIDTH-1:0]   dly_q [CIC_N_CH];
    logic [WIDTH-1:0]   dly_d [CIC_N_CH];
    logic [CIC_N_CH-1:0] prm_q;
    logic [CIC_N_CH-1:0] prm_d;

    // Output register
    logic               valid_q, valid_d;
    cic_ch_t            ch_q, ch_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               ovf_q, ovf_d;

    // Comb result produced this cycle
    logic               res_vld;
    logic [WIDTH-1:0]   res_data;

    // Decimation counting and comb difference for the addressed channel
    always_comb begin
        cnt_d    = cnt_q;
        dly_d    = dly_q;
        prm_d    = prm_q;
        res_vld  = 1'b0;
        res_data = data_i - dly_q[ch_i];
        if (valid_i) begin
            // ">=" rather than "==" so that lowering decim_i below a running
            // count fires on that channel's next sample.
            if (cnt_q[ch_i] >= decim_i) begin
                cnt_d[ch_i] = '0;
                dly_d[ch_i] = data_i;
                prm_d[ch_i] = 1'b1;
                res_vld     = prm_q[ch_i];
            end else begin
                cnt_d[ch_i] = cnt_q[ch_i] + CNT_ONE;
            end
        end
    end

    // Output register next state: load a result, drop it on stall, or retire it on handshake
    always_comb begin
        valid_d = valid_q;
        ch_d    = ch_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (res_vld) begin
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                ch_d    = ch_i;
                data_d  = res_data;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State registers: async reset, then synchronous clear, then normal update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < CIC_N_CH; i++) begin
                cnt_q[i] <= '0;
                dly_q[i] <= '0;
            end
            prm_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (clr_i) begin
            for (int i = 0; i < CIC_N_CH; i++) begin
                cnt_q[i] <= '0;
                dly_q[i] <= '0;
            end
            prm_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < CIC_N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                dly_q[i] <= dly_d[i];
            end
            prm_q   <= prm_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign ch_o    = ch_q;
    assign data_o  = data_q;
    assign ovf_o   = ovf_q;

endmodule : cic_comb_decim
